// File: rtl/logic32_pkg.sv
// logic32_pkg: opcode type, default width and ones-count helper
// shared by logic32_unit and its result FIFO.
package logic32_pkg;

  localparam int LOGIC32_W   = 32;
  localparam int POPCNT_IN_W = 64;
  localparam int POPCNT_OUT_W = 7;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  function automatic logic [POPCNT_OUT_W-1:0] popcnt(
    input logic [POPCNT_IN_W-1:0] v
  );
    logic [POPCNT_OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < POPCNT_IN_W; i++) begin
      n = n + POPCNT_OUT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/logic32_fifo.sv
// logic32_fifo: generic synchronous FIFO, power-of-two depth,
// async active-low reset; head is always presented combinationally.
module logic32_fifo
  import logic32_pkg::*;
#(
  parameter int WIDTH = LOGIC32_W,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        do_push & ~do_pop: count <= count + CW'(1);
        do_pop & ~do_push: count <= count - CW'(1);
        default:           count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/logic32_unit.sv
// logic32_unit: handshaked AND/OR/XOR/NOR unit with buffered results.
// Define LOGIC32_POPCNT_EN to add the per-result Popcnt output.
module logic32_unit
  import logic32_pkg::*;
#(
  parameter int WIDTH = LOGIC32_W,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  op_e              Op,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out,
  output logic             Zero
`ifdef LOGIC32_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] Popcnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);
`ifdef LOGIC32_POPCNT_EN
  localparam int PCW = $clog2(WIDTH+1);
  localparam int PW  = WIDTH + 1 + PCW;
`else
  localparam int PW  = WIDTH + 1;
`endif

  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic [PW-1:0]    wr_data;
  logic [PW-1:0]    head;
  logic [WIDTH-1:0] head_res;
  logic             head_zero;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             ready_q;

  always_comb begin
    res = '0;
    unique case (Op)
      OP_AND: res = In1 & In2;
      OP_OR:  res = In1 | In2;
      OP_XOR: res = In1 ^ In2;
      OP_NOR: res = ~(In1 | In2);
    endcase
  end

  assign res_zero = (res == '0);

`ifdef LOGIC32_POPCNT_EN
  logic [PCW-1:0] res_pc;
  assign res_pc  = PCW'(popcnt(POPCNT_IN_W'(res)));
  assign wr_data = {res, res_zero, res_pc};
  assign Popcnt  = empty ? '0 : head[PCW-1:0];
`else
  assign wr_data = {res, res_zero};
`endif

  assign head_res  = head[PW-1 -: WIDTH];
  assign head_zero = head[PW-1-WIDTH];

  assign push = In_Valid & ready_q;
  assign pop  = Out_Valid & Out_Ready;

  logic32_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Rst_n),
    .push  (push),
    .pop   (pop),
    .data  (wr_data),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign count_next = count + CW'(push) - CW'(pop);

  // A pop always leaves room; otherwise only a non-full next count does.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ready_q <= 1'b0;
    else        ready_q <= pop | (~full & (count_next < CW'(DEPTH)));
  end

  assign In_Ready  = ready_q;
  assign Out_Valid = ~empty;
  assign Out       = empty ? '0 : head_res;
  assign Zero      = empty ? 1'b1 : head_zero;

endmodule

// File: tb/tb_logic32_unit.sv
// tb_logic32_unit: scoreboard bench for logic32_unit with directed
// and randomized traffic against a behavioural result model.
`timescale 1ns/1ps
module tb_logic32_unit;
  import logic32_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         In_Valid = 1'b0;
  logic         Out_Ready = 1'b0;
  logic         In_Ready;
  logic         Out_Valid;
  logic         Zero;
  logic [W-1:0] In1 = '0;
  logic [W-1:0] In2 = '0;
  logic [W-1:0] Out;
  op_e          Op = OP_AND;
`ifdef LOGIC32_POPCNT_EN
  logic [5:0]   Popcnt;
`endif

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    int           pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   popped = 0;

  always #5 Clk = ~Clk;

  logic32_unit dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In1       (In1),
    .In2       (In2),
    .Op        (Op),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out       (Out),
    .Zero      (Zero)
`ifdef LOGIC32_POPCNT_EN
    ,
    .Popcnt    (Popcnt)
`endif
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, op_e op);
    exp_t e;
    case (op)
      OP_AND:  e.r = a & b;
      OP_OR:   e.r = a | b;
      OP_XOR:  e.r = a ^ b;
      default: e.r = ~(a | b);
    endcase
    e.z  = (e.r == '0);
    e.pc = $countones(e.r);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the push edge.
  task automatic send(logic [W-1:0] a, logic [W-1:0] b, op_e op);
    bit done = 1'b0;
    In1 = a;
    In2 = b;
    Op = op;
    In_Valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge Clk);
      if (In_Ready) begin
        exp_q.push_back(model(a, b, op));
        done = 1'b1;
      end
      @(posedge Clk);
      #1;
    end
    In_Valid = 1'b0;
    if (!done) check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    int n = 0;
    Out_Ready = 1'b1;
    while ((exp_q.size() != 0 || Out_Valid) && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size() == 0 && !Out_Valid), 64'(1));
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n) begin
      if (Out_Valid && Out_Ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_response", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          popped++;
          check("out", 64'(Out), 64'(e.r));
          check("zero", 64'(Zero), 64'(e.z));
`ifdef LOGIC32_POPCNT_EN
          check("popcnt", 64'(Popcnt), 64'(e.pc));
`endif
        end
      end else if (!Out_Valid) begin
        check("idle_out", 64'(Out), 64'(0));
        check("idle_zero", 64'(Zero), 64'(1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] t2 [4];
    exp_t v0;
    exp_t v1;
    exp_t e1;
    int   p0;
    logic [W-1:0] a;
    logic [W-1:0] b;

    t2[0] = 32'h00F0_1200;
    t2[1] = 32'hFFF0_FF34;
    t2[2] = 32'hFF00_ED34;
    t2[3] = 32'h000F_00CB;

    repeat (2) @(posedge Clk);
    #1;
    check("rst_in_ready", 64'(In_Ready), 64'(0));
    check("rst_out_valid", 64'(Out_Valid), 64'(0));
    check("rst_out", 64'(Out), 64'(0));
    check("rst_zero", 64'(Zero), 64'(1));
`ifdef LOGIC32_POPCNT_EN
    check("rst_popcnt", 64'(Popcnt), 64'(0));
`endif
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("ready_before_edge", 64'(In_Ready), 64'(0));
    @(posedge Clk);
    #1;
    check("ready_after_release", 64'(In_Ready), 64'(1));

    // Each op, head visible one cycle after its push
    Out_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'hF0F0_1234, 32'h0FF0_FF00, op_e'(i));
      check("op_valid", 64'(Out_Valid), 64'(1));
      check("op_result", 64'(Out), 64'(t2[i]));
    end
    drain();

    // Zero flag corners
    Out_Ready = 1'b0;
    send(32'hAAAA_AAAA, 32'h5555_5555, OP_AND);
    check("zero_and_out", 64'(Out), 64'(0));
    check("zero_and_flag", 64'(Zero), 64'(1));
    check("zero_and_valid", 64'(Out_Valid), 64'(1));
    drain();
    Out_Ready = 1'b0;
    send(32'h0, 32'h0, OP_NOR);
    check("nor_out", 64'(Out), 64'(32'hFFFF_FFFF));
    check("nor_zero", 64'(Zero), 64'(0));
`ifdef LOGIC32_POPCNT_EN
    check("nor_popcnt", 64'(Popcnt), 64'(32));
`endif
    drain();

    // Backpressure: two fill the FIFO, third waits
    Out_Ready = 1'b0;
    v0 = model(32'h1234_5678, 32'h0F0F_0F0F, OP_XOR);
    v1 = model(32'hDEAD_BEEF, 32'h00FF_00FF, OP_AND);
    send(32'h1234_5678, 32'h0F0F_0F0F, OP_XOR);
    send(32'hDEAD_BEEF, 32'h00FF_00FF, OP_AND);
    fork
      send(32'hCAFE_0000, 32'h0000_F00D, OP_OR);
    join_none
    repeat (3) begin
      check("bp_in_ready", 64'(In_Ready), 64'(0));
      check("bp_out_stable", 64'(Out), 64'(v0.r));
      check("bp_zero_stable", 64'(Zero), 64'(v0.z));
      @(posedge Clk);
      #1;
    end
    Out_Ready = 1'b1;
    @(posedge Clk);
    #1;
    check("bp_reopen", 64'(In_Ready), 64'(1));
    check("bp_next_head", 64'(Out), 64'(v1.r));
    wait fork;
    drain();

    // Simultaneous push and pop at count 1
    Out_Ready = 1'b0;
    send(32'h0000_FFFF, 32'h00FF_00FF, OP_OR);
    check("sim_count1_valid", 64'(Out_Valid), 64'(1));
    check("sim_count1_ready", 64'(In_Ready), 64'(1));
    e1 = model(32'h8000_0001, 32'h7FFF_FFFE, OP_NOR);
    Out_Ready = 1'b1;
    send(32'h8000_0001, 32'h7FFF_FFFE, OP_NOR);
    check("sim_new_head", 64'(Out), 64'(e1.r));
    check("sim_valid", 64'(Out_Valid), 64'(1));
    check("sim_ready", 64'(In_Ready), 64'(1));
    drain();

    // Wrap: Out_Ready toggling each cycle
    p0 = popped;
    fork
      for (int i = 0; i < 30; i++) begin
        Out_Ready = (i % 2 == 0);
        @(posedge Clk);
        #1;
      end
    join_none
    for (int i = 0; i < 10; i++) begin
      send($urandom, $urandom, op_e'(i % 4));
    end
    wait fork;
    drain();
    check("wrap_count", 64'(popped - p0), 64'(10));

    // Reset with two entries held
    Out_Ready = 1'b0;
    send(32'h1111_2222, 32'h3333_4444, OP_OR);
    send(32'h5555_6666, 32'h7777_8888, OP_XOR);
    check("pre_rst_full", 64'(In_Ready), 64'(0));
    #2;
    Rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", 64'(Out_Valid), 64'(0));
    check("mid_rst_in_ready", 64'(In_Ready), 64'(0));
    check("mid_rst_out", 64'(Out), 64'(0));
    check("mid_rst_zero", 64'(Zero), 64'(1));
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("mid_rel_ready0", 64'(In_Ready), 64'(0));
    @(posedge Clk);
    #1;
    check("mid_rel_ready1", 64'(In_Ready), 64'(1));
    check("mid_rel_empty", 64'(Out_Valid), 64'(0));

    // Randomized traffic with random consumer stalls
    p0 = popped;
    fork
      for (int i = 0; i < 400; i++) begin
        Out_Ready = 1'($urandom_range(0, 1));
        @(posedge Clk);
        #1;
      end
    join_none
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      send(a, b, op_e'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clk);
        #1;
      end
    end
    wait fork;
    drain();
    check("rand_count", 64'(popped - p0), 64'(150));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
